// File: rtl/mem_arbiter_if.sv
// Bundle of cpu-side (imem/dmem) and memory-side signals around mem_arbiter.
// master: the arbiter's view; slave: the cpu + memory environment's view.
interface mem_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        timeout;

    modport master (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_addr, mem_rmask, mem_wmask, mem_wdata, timeout
    );

    modport slave (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_addr, mem_rmask, mem_wmask, mem_wdata, timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges cpu imem/dmem ports onto one single-port memory via per-port pending buffers.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking instead of fixed dmem priority.
module mem_arbiter #(
    parameter int ALIGN_ADDR = 1,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;
    state_t state, state_n;

    logic          i_full, d_full;
    logic [31:0]   i_addr, d_addr, d_wdata;
    logic [3:0]    i_rmask, d_rmask, d_wmask;
    logic          i_resp, d_resp;
    logic [31:0]   i_rdata, d_rdata;
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;
    logic [31:0]   raw_addr;
    logic          i_cap, d_cap, i_avail, d_avail, d_win;

    assign i_cap   = (|bus.imem_rmask) && !i_full && !i_resp;
    assign d_cap   = (|(bus.dmem_rmask | bus.dmem_wmask)) && !d_full && !d_resp;
    // Grant looks at what the buffers hold after this edge, so a request
    // captured now is served from the buffer in the very next cycle.
    assign i_avail = i_full | i_cap;
    assign d_avail = d_full | d_cap;

`ifdef MEM_ARBITER_RR_EN
    logic last_grant;  // 1: dmem was served last

    assign d_win = d_avail && (!i_avail || !last_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b0;
        else if (state == IDLE && state_n == SERVE_D)
            last_grant <= 1'b1;
        else if (state == IDLE && state_n == SERVE_I)
            last_grant <= 1'b0;
    end
`else
    assign d_win = d_avail;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        raw_addr      = '0;
        bus.mem_rmask = '0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (d_win)        state_n = SERVE_D;
                else if (i_avail) state_n = SERVE_I;
            end
            SERVE_D: begin
                raw_addr      = d_addr;
                bus.mem_rmask = d_rmask;
                bus.mem_wmask = d_wmask;
                bus.mem_wdata = d_wdata;
                if (bus.mem_resp) state_n = IDLE;
            end
            SERVE_I: begin
                raw_addr      = i_addr;
                bus.mem_rmask = i_rmask;
                if (bus.mem_resp) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_addr = (ALIGN_ADDR != 0) ? {raw_addr[31:2], 2'b00} : raw_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_full  <= 1'b0;
            i_addr  <= '0;
            i_rmask <= '0;
        end else if (i_cap) begin
            i_full  <= 1'b1;
            i_addr  <= bus.imem_addr;
            i_rmask <= bus.imem_rmask;
        end else if (state == SERVE_I && bus.mem_resp) begin
            i_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_full  <= 1'b0;
            d_addr  <= '0;
            d_rmask <= '0;
            d_wmask <= '0;
            d_wdata <= '0;
        end else if (d_cap) begin
            d_full  <= 1'b1;
            d_addr  <= bus.dmem_addr;
            d_rmask <= bus.dmem_rmask;
            d_wmask <= bus.dmem_wmask;
            d_wdata <= bus.dmem_wdata;
        end else if (state == SERVE_D && bus.mem_resp) begin
            d_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_resp  <= 1'b0;
            d_resp  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_resp <= (state == SERVE_I) && bus.mem_resp;
            d_resp <= (state == SERVE_D) && bus.mem_resp;
            if (state == SERVE_I && bus.mem_resp) i_rdata <= bus.mem_rdata;
            if (state == SERVE_D && bus.mem_resp) d_rdata <= bus.mem_rdata;
        end
    end

    // Every SERVE is entered from IDLE, so clearing in IDLE restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE) begin
            wait_cnt  <= '0;
        end else if (!bus.mem_resp) begin
            if (wait_cnt != CW'(WAIT_LIMIT))
                wait_cnt <= wait_cnt + CW'(1);
            if (WAIT_LIMIT != 0 && (wait_cnt + CW'(1)) == CW'(WAIT_LIMIT))
                timeout_q <= 1'b1;
        end
    end

    assign bus.imem_resp  = i_resp;
    assign bus.dmem_resp  = d_resp;
    assign bus.imem_rdata = i_rdata;
    assign bus.dmem_rdata = d_rdata;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random cpu/memory traffic against a transaction-level model,
// plus directed latency, ordering, alignment, watchdog and reset scenarios.
module tb_mem_arbiter;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.ALIGN_ADDR(1), .WAIT_LIMIT(WL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // memory environment controls
    int       dly_lo = 0, dly_hi = 3;
    bit       never = 0, fix_en = 0, force_en = 0;
    logic     force_resp = 1'b0;
    logic [31:0] fix_val = '0;

    initial begin
        int w, d;
        w = 0; d = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = fix_en ? fix_val : $urandom;
            if (force_en) bus.mem_resp = force_resp;
            else if (rst) begin bus.mem_resp = 1'b0; w = 0; end
            else if ((|bus.mem_rmask) || (|bus.mem_wmask)) begin
                bus.mem_resp = (!never && w == d);
                w++;
            end else begin
                bus.mem_resp = 1'b0;
                w = 0;
                d = $urandom_range(dly_hi, dly_lo);
            end
        end
    end

    // Transaction model: index 0 = dmem, 1 = imem; m_act = port owning the bus or -1.
    logic        m_full [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_rmask[2];
    logic [3:0]  m_wmask[2];
    logic        m_resp [2];
    logic [31:0] m_rdata[2];
    int          m_act, m_wait;
    logic        m_to, m_lg;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_full[p] = 0; m_addr[p] = 0; m_wdata[p] = 0; m_rmask[p] = 0;
            m_wmask[p] = 0; m_resp[p] = 0; m_rdata[p] = 0;
        end
        m_act = -1; m_wait = 0; m_to = 0; m_lg = 0;
    endtask

    task automatic model_step();
        logic nr[2];
        int   win;
        if (rst) begin model_reset(); return; end
        if (!m_full[0] && !m_resp[0] && (bus.dmem_rmask | bus.dmem_wmask) != 4'h0) begin
            m_full[0] = 1; m_addr[0] = bus.dmem_addr; m_rmask[0] = bus.dmem_rmask;
            m_wmask[0] = bus.dmem_wmask; m_wdata[0] = bus.dmem_wdata;
        end
        if (!m_full[1] && !m_resp[1] && bus.imem_rmask != 4'h0) begin
            m_full[1] = 1; m_addr[1] = bus.imem_addr; m_rmask[1] = bus.imem_rmask;
            m_wmask[1] = 0; m_wdata[1] = 0;
        end
        nr[0] = 0; nr[1] = 0;
        if (m_act >= 0) begin
            if (bus.mem_resp) begin
                nr[m_act] = 1; m_rdata[m_act] = bus.mem_rdata; m_full[m_act] = 0; m_act = -1;
            end else begin
                m_wait++;
                if (m_wait == WL) m_to = 1;
            end
        end else if (m_full[0] || m_full[1]) begin
            if (m_full[0] && m_full[1]) begin
`ifdef MEM_ARBITER_RR_EN
                win = m_lg ? 1 : 0;
`else
                win = 0;
`endif
            end else begin
                win = m_full[0] ? 0 : 1;
            end
            m_act = win; m_wait = 0; m_lg = (win == 0);
        end
        m_resp[0] = nr[0]; m_resp[1] = nr[1];
    endtask

    task automatic compare();
        logic [31:0] ea;
        logic [3:0]  erm, ewm;
        ea = 0; erm = 0; ewm = 0;
        if (m_act >= 0) begin
            ea = {m_addr[m_act][31:2], 2'b00}; erm = m_rmask[m_act]; ewm = m_wmask[m_act];
            check("mem_addr", bus.mem_addr, ea);
        end
        if (ewm != 4'h0) check("mem_wdata", bus.mem_wdata, m_wdata[m_act]);
        check("mem_rmask", 32'(bus.mem_rmask), 32'(erm));
        check("mem_wmask", 32'(bus.mem_wmask), 32'(ewm));
        check("dmem_resp", 32'(bus.dmem_resp), 32'(m_resp[0]));
        check("imem_resp", 32'(bus.imem_resp), 32'(m_resp[1]));
        check("dmem_rdata", bus.dmem_rdata, m_rdata[0]);
        check("imem_rdata", bus.imem_rdata, m_rdata[1]);
        check("timeout", 32'(bus.timeout), 32'(m_to));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!rst) compare();
        end
    end

    task automatic wait_port(input bit dport, input string nm);
        int k;
        k = 0;
        while (!(dport ? bus.dmem_resp : bus.imem_resp) && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k < 20) n_pass++;
        else $display("FAIL %s: no resp after %0d cycles, limit 20", nm, k);
        @(negedge clk);
        if (dport) begin bus.dmem_rmask = 0; bus.dmem_wmask = 0; end
        else bus.imem_rmask = 0;
    endtask

    initial begin
        int ist, dst, iage, dage, td, ti;
        bit issue;
        bus.imem_addr = 0; bus.imem_rmask = 0;
        bus.dmem_addr = 0; bus.dmem_rmask = 0; bus.dmem_wmask = 0; bus.dmem_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_rmask", 32'(bus.mem_rmask), 0);
        check("rst_mem_wmask", 32'(bus.mem_wmask), 0);
        check("rst_imem_resp", 32'(bus.imem_resp), 0);
        check("rst_dmem_resp", 32'(bus.dmem_resp), 0);
        check("rst_imem_rdata", bus.imem_rdata, 0);
        check("rst_dmem_rdata", bus.dmem_rdata, 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        #1 rst = 1'b0;

        // random traffic: each port issues, holds through its resp, then moves on
        ist = 0; dst = 0; iage = 0; dage = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            issue = (c < 500);
            if (ist == 1) begin
                if (bus.imem_resp) ist = 2;
                else begin
                    iage++;
                    bus.imem_addr  = $urandom;
                    bus.imem_rmask = 4'($urandom_range(15, 1));
                    if (iage > 40) begin
                        n_chk++; ist = 0;
                        $display("FAIL imem_wait: waited %0d cycles, limit 40", iage);
                    end
                end
            end else if (issue && $urandom_range(2, 0) == 0) begin
                bus.imem_addr = $urandom; bus.imem_rmask = 4'($urandom_range(15, 1));
                ist = 1; iage = 0;
            end else begin
                bus.imem_addr = $urandom; bus.imem_rmask = 0; ist = 0;
            end
            if (dst == 1) begin
                if (bus.dmem_resp) dst = 2;
                else begin
                    dage++;
                    bus.dmem_addr  = $urandom;
                    bus.dmem_wdata = $urandom;
                    if (dage > 40) begin
                        n_chk++; dst = 0;
                        $display("FAIL dmem_wait: waited %0d cycles, limit 40", dage);
                    end
                end
            end else if (issue && $urandom_range(2, 0) == 0) begin
                bus.dmem_addr = $urandom; bus.dmem_wdata = $urandom;
                if ($urandom_range(1, 0) == 1) begin
                    bus.dmem_wmask = 4'($urandom_range(15, 1)); bus.dmem_rmask = 0;
                end else begin
                    bus.dmem_rmask = 4'($urandom_range(15, 1)); bus.dmem_wmask = 0;
                end
                dst = 1; dage = 0;
            end else begin
                bus.dmem_addr = $urandom; bus.dmem_rmask = 0; bus.dmem_wmask = 0; dst = 0;
            end
        end
        bus.imem_rmask = 0; bus.dmem_rmask = 0; bus.dmem_wmask = 0;
        repeat (5) @(negedge clk);

        // lone fetch on zero-wait memory
        dly_lo = 0; dly_hi = 0; fix_en = 1; fix_val = 32'h0000_0013;
        @(negedge clk);
        bus.imem_addr = 32'h1eceb000; bus.imem_rmask = 4'hf;
        @(negedge clk);
        check("fetch_addr", bus.mem_addr, 32'h1eceb000);
        check("fetch_rmask", 32'(bus.mem_rmask), 32'hf);
        @(negedge clk);
        check("fetch_resp", 32'(bus.imem_resp), 1);
        check("fetch_rdata", bus.imem_rdata, 32'h0000_0013);
        @(negedge clk);
        check("fetch_resp_once", 32'(bus.imem_resp), 0);
        check("fetch_no_dup", 32'(bus.mem_rmask), 0);
        bus.imem_rmask = 0;
        @(negedge clk);
        check("fetch_no_dup2", 32'(bus.mem_rmask), 0);
        fix_en = 0;

        // misaligned load
        bus.dmem_addr = 32'h1eceb103; bus.dmem_rmask = 4'h8; bus.dmem_wmask = 0;
        @(negedge clk);
        check("mis_addr", bus.mem_addr, 32'h1eceb100);
        check("mis_rmask", 32'(bus.mem_rmask), 32'h8);
        wait_port(1'b1, "mis_resp");
        @(negedge clk);

        // simultaneous fetch and store
        bus.imem_addr = 32'h1eceb004; bus.imem_rmask = 4'hf;
        bus.dmem_addr = 32'h1eceb100; bus.dmem_wmask = 4'h3; bus.dmem_rmask = 0;
        bus.dmem_wdata = 32'hdeadbeef;
        td = -1; ti = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
`ifdef MEM_ARBITER_RR_EN
                check("sim_first_rmask", 32'(bus.mem_rmask), 32'hf);
                check("sim_first_addr", bus.mem_addr, 32'h1eceb004);
`else
                check("sim_first_wmask", 32'(bus.mem_wmask), 32'h3);
                check("sim_first_wdata", bus.mem_wdata, 32'hdeadbeef);
                check("sim_first_addr", bus.mem_addr, 32'h1eceb100);
`endif
            end
            if (td >= 0 && k == td + 1) begin bus.dmem_wmask = 0; bus.dmem_rmask = 0; end
            if (ti >= 0 && k == ti + 1) bus.imem_rmask = 0;
            if (bus.dmem_resp && td < 0) td = k;
            if (bus.imem_resp && ti < 0) ti = k;
        end
        check("sim_both_done", 32'((td > 0) && (ti > 0)), 1);
`ifdef MEM_ARBITER_RR_EN
        check("sim_order_gap", 32'((td - ti) >= 2), 1);
`else
        check("sim_order_gap", 32'((ti - td) >= 2), 1);
`endif

        // memory delays mem_resp by 5 cycles
        dly_lo = 5; dly_hi = 5;
        @(negedge clk);
        bus.imem_addr = 32'h1eceb008; bus.imem_rmask = 4'hf;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("dly_rmask", 32'(bus.mem_rmask), 32'hf);
            check("dly_addr", bus.mem_addr, 32'h1eceb008);
            check("dly_no_resp", 32'(bus.imem_resp), 0);
        end
        @(negedge clk);
        check("dly_resp", 32'(bus.imem_resp), 1);
        check("dly_timeout", 32'(bus.timeout), 1);
        @(negedge clk);
        bus.imem_rmask = 0;
        dly_lo = 0; dly_hi = 3;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_clears_timeout", 32'(bus.timeout), 0);
        #1 rst = 1'b0;

        // memory never responds
        never = 1;
        @(negedge clk);
        bus.imem_addr = 32'h1eceb00c; bus.imem_rmask = 4'hf;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("wd_timeout", 32'(bus.timeout), 32'(k >= 5));
            check("wd_still_serving", 32'(bus.mem_rmask), 32'hf);
        end
        rst = 1'b1; bus.imem_rmask = 0;
        @(negedge clk);
        #1 rst = 1'b0;

        // async reset mid-SERVE_D, then a stray mem_resp
        @(negedge clk);
        bus.dmem_addr = 32'h1eceb200; bus.dmem_wmask = 4'hf; bus.dmem_rmask = 0;
        bus.dmem_wdata = 32'h12345678;
        @(negedge clk);
        check("srv_wmask", 32'(bus.mem_wmask), 32'hf);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_wmask", 32'(bus.mem_wmask), 0);
        check("arst_rmask", 32'(bus.mem_rmask), 0);
        check("arst_dmem_resp", 32'(bus.dmem_resp), 0);
        check("arst_imem_resp", 32'(bus.imem_resp), 0);
        check("arst_timeout", 32'(bus.timeout), 0);
        bus.dmem_wmask = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0; never = 0; force_resp = 1'b1; force_en = 1;
        @(negedge clk);
        #1 force_resp = 1'b0;
        @(negedge clk);
        check("stray_dmem_resp", 32'(bus.dmem_resp), 0);
        check("stray_imem_resp", 32'(bus.imem_resp), 0);
        check("stray_wmask", 32'(bus.mem_wmask), 0);
        @(negedge clk);
        check("stray_dmem_resp2", 32'(bus.dmem_resp), 0);
        force_en = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the pipelined RV32I cpu.
- Merges the cpu's independent imem and dmem request ports onto one unified single-port memory interface.
- Captures each cpu request into a per-port pending buffer, serialises the buffers onto the memory bus, and returns a one-cycle response pulse with read data to the originating port.
- Keeps both cpu ports oblivious to contention; the cpu stalls until its resp arrives.

Parameters:
- ALIGN_ADDR, 1, when 1 force mem_addr[1:0] to 2'b00 on the memory side; when 0 pass the address unchanged.
- WAIT_LIMIT, 1023, maximum cycles a memory access may wait for mem_resp before the timeout flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  in  32  instruction fetch address
- imem_rmask  in  4  fetch read mask; nonzero means a request
- imem_rdata  out  32  fetch data, valid when imem_resp
- imem_resp  out  1  one-cycle fetch completion pulse
- dmem_addr  in  32  data address
- dmem_rmask  in  4  load mask
- dmem_wmask  in  4  store mask
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid when dmem_resp
- dmem_resp  out  1  one-cycle data completion pulse
- mem_addr  out  32  unified memory address
- mem_rmask  out  4  unified read mask
- mem_wmask  out  4  unified write mask
- mem_wdata  out  32  unified write data
- mem_rdata  in  32  unified read data
- mem_resp  in  1  unified completion, one cycle
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, immediate): state IDLE; both pending buffers empty; all outputs 0, including mem_rmask, mem_wmask, both resp pulses, both rdata outputs, and timeout. A transaction in flight at reset is abandoned; a mem_resp arriving after reset deasserts is ignored.
- Request definitions:
  - dmem request: dmem_rmask|dmem_wmask nonzero.
  - imem request: imem_rmask nonzero.
- Capture rule: a port's request is latched (addr, masks, wdata) at a clock edge only if:
  - that port's buffer is empty, and
  - that port's resp is not asserted in that cycle.
- After capture, the cpu may change or hold its inputs; they are ignored until the resp pulse. This lets the cpu hold a request across the resp cycle without a duplicate access.
- FSM states: IDLE, SERVE_D, SERVE_I.
  - IDLE -> SERVE_D if the d buffer is full, else -> SERVE_I if the i buffer is full. Evaluation uses buffer contents, so a request captured at edge t is eligible in cycle t+1.
  - SERVE_x: mem_* driven from buffer x. Drives come from registered state, not combinationally from cpu inputs.
  - SERVE_x on mem_resp: latch mem_rdata into x_rdata, pulse x_resp the next cycle, empty buffer x, and return to IDLE (mem_* masks 0 that cycle).
- Minimum latency, for a zero-wait memory: request visible at cycle t, captured at edge t, mem masks driven cycle t+1, mem_resp at t+1, x_resp at t+2.
- Arbitration with both buffers full: dmem wins (fixed priority). An imem fetch waits for at most one data access, because the cpu never issues a second dmem request before receiving its resp.
- A store returns dmem_resp with dmem_rdata equal to whatever mem_rdata held at mem_resp; the cpu ignores it.
- x_rdata holds its last value between pulses.
- Watchdog:
  - A counter clears on entering SERVE_x and increments each SERVE cycle without mem_resp.
  - When the count reaches WAIT_LIMIT (and WAIT_LIMIT != 0), timeout sets and stays set until reset.
  - The FSM keeps waiting and is not aborted.
- Address: when ALIGN_ADDR=1, mem_addr = {buf_addr[31:2], 2'b00}; masks pass through unchanged.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin arbitration. A last_grant bit records the port last served; when both buffers are full in IDLE, the port not last served wins. last_grant resets to imem, so dmem wins the first tie.
- Undefined: fixed dmem priority, as above; no last_grant register exists.

Test Plan:
- Lone fetch, imem_addr=0x1eceb000, rmask=4'hf, zero-wait memory returning 0x00000013 -> mem_addr=0x1eceb000 and mem_rmask=4'hf in cycle t+1; imem_resp=1 with imem_rdata=0x00000013 in cycle t+2, one cycle only; no second access while the cpu holds the request through the resp cycle.
- Simultaneous fetch 0x1eceb004 and store dmem_addr=0x1eceb100, wmask=4'h3, wdata=0xdeadbeef -> store issued first with mem_wmask=4'h3 and mem_wdata=0xdeadbeef, then the fetch; dmem_resp precedes imem_resp by ≥2 cycles. With MEM_ARBITER_RR_EN after a prior dmem grant -> the fetch goes first.
- Misaligned load dmem_addr=0x1eceb103, rmask=4'h8, ALIGN_ADDR=1 -> mem_addr=0x1eceb100 and mem_rmask=4'h8.
- Memory delays mem_resp by 5 cycles -> mem_* held stable for 6 cycles; resp arrives 1 cycle after mem_resp.
- WAIT_LIMIT=4 and memory never responds -> timeout=1 exactly 4 cycles into SERVE, and it stays 1.
- Assert rst mid-SERVE_D -> mem_wmask, mem_rmask and resp outputs 0 immediately (same cycle, asynchronous); a stray mem_resp after reset produces no dmem_resp.
